kairo_mul: RTL and testbench
============================

# kairo_mul

Multi-cycle RV32M multiplier executing MUL, MULH, MULHSU and MULHU. It is the multiply counterpart of the core's iterative divide unit and shares that unit's WAIT/READY stall handshake to the execute stage, so the pipeline drives both units identically. It uses a radix-2 shift-add datapath over sign-corrected magnitudes: one 64-bit adder, no DSP dependence, and a fixed 34-cycle occupancy.

## Interface
- No parameters.
- RST_N  input  1  synchronous active-low reset.
- CLK  input  1  clock.
- INST_MUL  input  1  decoded MUL; level, held by the core until READY.
- INST_MULH  input  1  decoded MULH (signed × signed, high word).
- INST_MULHSU  input  1  decoded MULHSU (signed RS1 × unsigned RS2, high word).
- INST_MULHU  input  1  decoded MULHU (unsigned × unsigned, high word).
- RS1  input  32  multiplicand operand; sampled only in IDLE on start.
- RS2  input  32  multiplier operand; sampled only in IDLE on start.
- WAIT  output  1  stall request, `(state != FIN) & start`.
- READY  output  1  result valid, `state == FIN`.
- RD  output  32  result; valid while READY is high and held until the next start.

## Operation
- **Start:** `start = INST_MUL | INST_MULH | INST_MULHSU | INST_MULHU`. The core guarantees the INST_* inputs are one-hot. If more than one is high, priority is MULH > MULHSU > MULHU > MUL.
- **Signedness flags:**
  - `s1` = MULH | MULHSU.
  - `s2` = MULH.
- **IDLE → EXEC on start.** The block captures:
  - `mcand[63:0] = {32'b0, (s1 & RS1[31]) ? -RS1 : RS1}`.
  - `mplier[31:0] = (s2 & RS2[31]) ? -RS2 : RS2`.
  - `neg = (s1 & RS1[31]) ^ (s2 & RS2[31])`.
  - `prod = 0`, `cnt = 0`.
  - `sel_hi = ~INST_MUL` (priority-resolved).
  - The magnitude of 0x80000000 is 0x80000000, interpreted as unsigned; no overflow handling is needed.
- **EXEC, one iteration per cycle:**
  - If `mplier[0]`, then `prod <= prod + mcand` (64-bit, wrap-free by construction).
  - `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `cnt <= cnt + 1`.
  - When `cnt == 31`, go to FIN. This gives exactly 32 iterations.
- **FIN:** unconditionally go to IDLE after one cycle. Start is ignored in FIN.
- **Result (combinational from registers):**
  - `p = neg ? -prod : prod` (64-bit two's complement).
  - `RD = sel_hi ? p[63:32] : p[31:0]`.
  - A zero product with `neg = 1` yields 0.
- **Registers:** `prod`, `neg` and `sel_hi` retain their values in IDLE, so RD stays stable after FIN until the next start.
- **Reset values:** state = IDLE; `prod`, `mcand`, `mplier`, `cnt`, `neg`, `sel_hi` = 0. Therefore RD = 0 and READY = 0. WAIT equals `start` (combinational).

## Timing
- Cycle 0: IDLE with start high. WAIT = 1; operands are latched.
- Cycles 1–32: EXEC. WAIT = 1 while start is held.
- Cycle 33: FIN. READY = 1, WAIT = 0, RD valid. The core deasserts INST_* on the following edge.
- Cycle 34: IDLE. If start is still high, a new operation begins with the current RS1/RS2. The core prevents this by deasserting.
- Total latency is 34 cycles from first start to IDLE, independent of operand values. There is no early termination.
- Operand changes during EXEC/FIN are ignored.
- Start dropping mid-EXEC does not abort the operation. WAIT goes low, the operation completes, and READY still pulses.
- Reset asserted in any state forces IDLE and the register reset values on the next edge. A partial result is discarded and READY never pulses for it.

## Test plan
- **Basic MUL:** MUL, RS1 = 7, RS2 = 6 → WAIT high in cycles 0–32, READY only in cycle 33 with RD = 0x0000002A. Back in IDLE at cycle 34.
- **Signed MUL and MULH:**
  - MUL, RS1 = 0xFFFFFFFD (−3), RS2 = 5 → RD = 0xFFFFFFF1.
  - MULH with the same operands → RD = 0xFFFFFFFF.
- **Extremes:**
  - MULH, RS1 = RS2 = 0x80000000 → RD = 0x40000000.
  - MULHU, RS1 = RS2 = 0xFFFFFFFF → RD = 0xFFFFFFFE.
  - MUL with the same operands → RD = 0x00000001.
- **Mixed signedness and zero:**
  - MULHSU, RS1 = 0xFFFFFFFF (−1), RS2 = 0xFFFFFFFF → RD = 0xFFFFFFFF.
  - MULH, RS1 = 0, RS2 = 0xFFFFFFFB → RD = 0.
- **Operand isolation and result hold:** change RS1/RS2 randomly during EXEC → result matches the cycle-0 operands. After FIN, with start low, RD holds its value for ≥ 5 cycles.
- **Reset mid-operation:** assert RST_N = 0 at cycle 15 of a MULHU, release at cycle 17 with start low → READY never asserts and RD = 0. A following MUL 3 × 4 returns 0x0000000C with full 34-cycle timing.

Source files
------------

// File: rtl/kairo_mul.sv
// kairo_mul: iterative RV32M multiplier (MUL, MULH, MULHSU, MULHU).
// Radix-2 shift-add over sign-corrected magnitudes, fixed 34-cycle occupancy.
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   INST_MUL/MULH/MULHSU/MULHU  decoded opcode levels, held until READY
//   RS1, RS2              operands, sampled only when a start is accepted in IDLE
//   WAIT                  stall request to execute stage
//   READY                 result valid (one cycle, in FIN)
//   RD                    result, held until the next start
module kairo_mul (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        INST_MUL,
   input  logic        INST_MULH,
   input  logic        INST_MULHSU,
   input  logic        INST_MULHU,
   input  logic [31:0] RS1,
   input  logic [31:0] RS2,
   output logic        WAIT,
   output logic        READY,
   output logic [31:0] RD
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned PLEN = 64;
   localparam int unsigned CW   = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   logic [1:0]      state, state_n;
   logic [PLEN-1:0] prod, prod_n;
   logic [PLEN-1:0] mcand, mcand_n;
   logic [XLEN-1:0] mplier, mplier_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            neg, neg_n;
   logic            sel_hi, sel_hi_n;

   logic            start;
   logic            neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic [PLEN-1:0] p;

   // Operand decode; MULH outranks MULHSU, so the raw ORs already match priority
   assign start = INST_MUL | INST_MULH | INST_MULHSU | INST_MULHU;
   assign neg1  = (INST_MULH | INST_MULHSU) & RS1[XLEN-1];
   assign neg2  = INST_MULH & RS2[XLEN-1];
   assign mag1  = neg1 ? XLEN'(32'd0 - RS1) : RS1;
   assign mag2  = neg2 ? XLEN'(32'd0 - RS2) : RS2;

   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= ST_IDLE;
         prod   <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         sel_hi <= 1'b0;
      end else begin
         state  <= state_n;
         prod   <= prod_n;
         mcand  <= mcand_n;
         mplier <= mplier_n;
         cnt    <= cnt_n;
         neg    <= neg_n;
         sel_hi <= sel_hi_n;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_n  = state;
      prod_n   = prod;
      mcand_n  = mcand;
      mplier_n = mplier;
      cnt_n    = cnt;
      neg_n    = neg;
      sel_hi_n = sel_hi;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n  = ST_EXEC;
               mcand_n  = {32'd0, mag1};
               mplier_n = mag2;
               neg_n    = neg1 ^ neg2;
               prod_n   = '0;
               cnt_n    = '0;
               // any high-word opcode wins over MUL
               sel_hi_n = INST_MULH | INST_MULHSU | INST_MULHU;
            end
         end
         ST_EXEC: begin
            if (mplier[0]) begin
               prod_n = prod + mcand;
            end
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + CW'(1);
            if (cnt == CW'(31)) begin
               state_n = ST_FIN;
            end
         end
         ST_FIN: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Handshake and result, decoded from registers
   assign WAIT  = (state != ST_FIN) & start;
   assign READY = (state == ST_FIN);
   assign p     = neg ? PLEN'(64'd0 - prod) : prod;
   assign RD    = sel_hi ? p[63:32] : p[31:0];

endmodule

// File: tb/tb_kairo_mul.sv
// tb_kairo_mul: scoreboard bench for kairo_mul. Expected results are queued when
// an operation is driven and compared when READY is observed.
module tb_kairo_mul;

   localparam logic [3:0] OP_MUL    = 4'b0001;
   localparam logic [3:0] OP_MULH   = 4'b0010;
   localparam logic [3:0] OP_MULHSU = 4'b0100;
   localparam logic [3:0] OP_MULHU  = 4'b1000;

   logic        CLK;
   logic        RST_N;
   logic        INST_MUL, INST_MULH, INST_MULHSU, INST_MULHU;
   logic [31:0] RS1, RS2;
   logic        WAIT, READY;
   logic [31:0] RD;

   int          n_checks;
   int          n_pass;
   logic [31:0] sb[$];
   logic [31:0] last_exp;

   kairo_mul dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .INST_MUL    (INST_MUL),
      .INST_MULH   (INST_MULH),
      .INST_MULHSU (INST_MULHSU),
      .INST_MULHU  (INST_MULHU),
      .RS1         (RS1),
      .RS2         (RS2),
      .WAIT        (WAIT),
      .READY       (READY),
      .RD          (RD)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Reference: extend operands per signedness, full 64-bit product, pick word
   function automatic logic [31:0] model(input logic [3:0] inst, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea, eb, pr;
      logic        s1, s2, hi;
      s1 = inst[1] | inst[2];
      s2 = inst[1];
      hi = inst[1] | inst[2] | inst[3];
      ea = s1 ? {{32{a[31]}}, a} : {32'd0, a};
      eb = s2 ? {{32{b[31]}}, b} : {32'd0, b};
      pr = ea * eb;
      return hi ? pr[63:32] : pr[31:0];
   endfunction

   task automatic drive_inst(input logic [3:0] inst);
      {INST_MULHU, INST_MULHSU, INST_MULH, INST_MUL} = inst;
   endtask

   // One full operation with cycle-accurate handshake checks
   task automatic run_op(input string tag, input logic [3:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit scramble);
      bit          ok;
      logic [31:0] e;
      @(negedge CLK);
      drive_inst(inst);
      RS1 = a;
      RS2 = b;
      sb.push_back(exp);
      #1;
      check({tag, "_c0_hs"}, 32'({WAIT, READY}), 32'b10);
      ok = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         @(negedge CLK);
         if ({WAIT, READY} !== 2'b10) ok = 1'b0;
         if (scramble) begin
            RS1 = $urandom;
            RS2 = $urandom;
         end
      end
      check({tag, "_exec_hs"}, 32'(ok), 32'd1);
      @(negedge CLK);
      check({tag, "_fin_hs"}, 32'({WAIT, READY}), 32'b01);
      if (sb.size() == 0) begin
         check({tag, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         last_exp = e;
         check({tag, "_rd"}, RD, e);
      end
      drive_inst(4'b0000);
      @(negedge CLK);
      check({tag, "_idle_ready"}, 32'(READY), 32'd0);
   endtask

   initial begin
      bit          ok;
      logic [3:0]  op;
      logic [31:0] a, b;
      n_checks = 0;
      n_pass   = 0;
      last_exp = '0;
      RST_N    = 1'b0;
      drive_inst(4'b0000);
      RS1 = '0;
      RS2 = '0;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_ready", 32'(READY), 32'd0);
      check("rst_rd", RD, 32'd0);
      check("rst_wait_idle", 32'(WAIT), 32'd0);
      INST_MUL = 1'b1;
      #1;
      check("rst_wait_start", 32'(WAIT), 32'd1);
      INST_MUL = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;

      // Directed vectors
      run_op("mul_7x6",      OP_MUL,    32'd7,        32'd6,        32'h0000002A, 1'b0);
      run_op("mul_neg",      OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0);
      run_op("mulh_neg",     OP_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 1'b0);
      run_op("mulh_min",     OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
      run_op("mulhu_max",    OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      run_op("mul_max",      OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      run_op("mulhsu_m1",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op("mulh_zero",    OP_MULH,   32'd0,        32'hFFFFFFFB, 32'd0,        1'b0);
      run_op("prio_mulh",    OP_MULH | OP_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 1'b0);
      run_op("mulhsu_mixed", OP_MULHSU, 32'h12345678, 32'h9ABCDEF0,
             model(OP_MULHSU, 32'h12345678, 32'h9ABCDEF0), 1'b1);

      // Result hold with start low
      ok = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         RS1 = $urandom;
         RS2 = $urandom;
         if (RD !== last_exp || READY !== 1'b0) ok = 1'b0;
      end
      check("hold_rd", 32'(ok), 32'd1);

      // Random ops with operands scrambled during EXEC
      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 3))
            0:       op = OP_MUL;
            1:       op = OP_MULH;
            2:       op = OP_MULHSU;
            default: op = OP_MULHU;
         endcase
         a = $urandom;
         b = $urandom;
         run_op($sformatf("rand%0d", i), op, a, b, model(op, a, b), 1'b1);
      end

      // Reset mid-operation: partial MULHU is discarded
      @(negedge CLK);
      drive_inst(OP_MULHU);
      RS1 = 32'hFFFFFFFF;
      RS2 = 32'hFFFFFFFF;
      ok = 1'b1;
      repeat (15) begin
         @(negedge CLK);
         if (READY !== 1'b0) ok = 1'b0;
      end
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      drive_inst(4'b0000);
      check("midrst_rd", RD, 32'd0);
      repeat (40) begin
         @(negedge CLK);
         if (READY !== 1'b0 || RD !== 32'd0) ok = 1'b0;
      end
      check("midrst_no_ready", 32'(ok), 32'd1);
      run_op("mul_3x4", OP_MUL, 32'd3, 32'd4, 32'h0000000C, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
